mips_multicycle_vn_ws: RTL and testbench
========================================

// Module: mips_multicycle_vn_ws
// PURPOSE
//  Next-generation multicycle MIPS core, von Neumann (one shared instruction/data port).
//  Adds a req/rdy memory handshake with arbitrary wait states, a bus timeout and a sticky FAULT
//  state, a parametrised reset vector, and a retired-instruction counter.
//  Sits between the board top level and the unified memory-mapped memory/IO fabric.
// PARAMETERS
//  N          32            datapath/address width; only 32 is supported
//  RESET_PC   32'h00400000  PC loaded on reset
//  MEM_TMO    16            cycles a request may wait for mem_rdy before FAULT (>=1)
//  CNT_W      32            width of retired-instruction counter
// PORTS
//  clk                 in   1       clock; all state updates on posedge
//  rst                 in   1       synchronous, active-high reset
//  ena                 in   1       0 = freeze all state (counters, timeout, FSM); mem_req forced 0
//  mem_addr            out  N       byte address of current transaction (word-aligned)
//  mem_wr_data         out  N       store data (valid when mem_wr_ena=1)
//  mem_wr_ena          out  1       1 = write transaction, 0 = read
//  mem_req             out  1       transaction request
//  mem_rdy             in   1       transaction completes in any cycle with mem_req & mem_rdy
//  mem_rd_data         in   N       read data, sampled in the completing cycle
//  PC                  out  N       address of the instruction being executed
//  full_register_file  out  32*N    flattened r0..r31 (r0 at LSBs) from register_file
//  fault               out  1       sticky; core is in S_FAULT
//  retired             out  CNT_W   instructions completed since reset (wraps mod 2^CNT_W)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=FETCH, PC=RESET_PC, retired=0, fault=0, timeout count=0,
//   registers r0..r31=0. mem_req=0 and mem_wr_ena=0 whenever rst=1 or ena=0.
//  Handshake: while mem_req=1, mem_addr/mem_wr_data/mem_wr_ena are stable until the completing
//   cycle. mem_rdy with mem_req=0 is ignored. At most one transaction per FETCH/MEMORY visit.
//  FSM: FETCH -> DECODE -> EXECUTE -> {MEMORY, WRITEBACK, FETCH}; MEMORY -> {WRITEBACK, FETCH};
//   WRITEBACK -> FETCH; any -> FAULT on error; FAULT is absorbing until rst.
//   FETCH: mem_req=1, read at PC; on completion IR<=mem_rd_data, PC4<=PC+4, go DECODE.
//   DECODE: A<=rf[rs], B<=rf[rt]; undefined opcode/funct -> FAULT.
//   EXECUTE: ALU op; branches/jumps resolve and write PC here, go FETCH.
//   MEMORY: lw read / sw write at A+sext(imm); lw completion -> WRITEBACK, sw completion -> FETCH.
//   WRITEBACK: one register write; retired increments in the last cycle of every instruction.
//  Non-branch PC update: PC<=PC4 in the final cycle of the instruction.
//  Latency with mem_rdy tied 1: ALU R/I 4 cycles, sw 4, lw 5, beq/bne/j/jal/jr 3. Each wait cycle
//   adds 1.
//  ISA: R: add addu sub subu and or xor nor slt sltu sll srl sra jr; I: addi addiu slti sltiu
//   andi ori xori lui lw sw beq bne; J: j jal. add/sub/addi overflow is ignored (no trap).
//  Immediates: sign-extend for addi/addiu/slti/sltiu/lw/sw/beq/bne; zero-extend andi/ori/xori;
//   lui = {imm,16'b0}. Shifts use IR[10:6] on rt.
//  Targets: branch PC4+(sext(imm)<<2) if taken else PC4; j/jal {PC4[31:28],IR[25:0],2'b00};
//   jal writes PC4 to r31 in EXECUTE; jr PC<=A.
//  Writes to r0 are discarded; rd for R-type, rt for I-type/lw.
//  Faults: undefined instruction; lw/sw address[1:0]!=0; jr target[1:0]!=0; a request pending
//   MEM_TMO cycles without mem_rdy. On fault, PC holds the faulting instruction's address.
//   No register write or store occurs for the faulting instruction, and retired does not
//   increment.
//  ena=0 mid-wait: the request drops and the timeout count holds. The same transaction
//   re-issues when ena=1.
//  rst mid-transaction: the transaction is abandoned and memory must tolerate req dropping.
// TESTING
//  addi r1,r0,-5; addiu r2,r0,7; add r3,r1,r2, mem_rdy=1 -> r3=2, retired=3 after 12 cycles
//  sw r3,0x10(r0), then lw r4,0x10(r0), with 3 wait states each -> mem store then r4=2;
//   addr/data stable across the waits
//  beq r0,r0,+2 at RESET_PC -> PC=RESET_PC+12; bne untaken falls through; jal sets r31=PC+4
//  ori r5,r0,0x8000; lui r6,0x1234 -> r5=32'h00008000, r6=32'h12340000
//  mem_rdy held 0 on fetch -> fault=1 after MEM_TMO cycles, PC unchanged, retired frozen;
//   rst clears it
//  lw from address 0x2 -> fault; opcode 6'h3F -> fault; ena=0 for 5 cycles mid-lw -> result
//   identical, delayed by 5 cycles

Source files
------------

// File: rtl/mips_multicycle_vn_ws.sv
// Multicycle MIPS core with a single shared instruction/data port, req/rdy wait states,
// bus timeout into a sticky FAULT state, and a retired-instruction counter.
module mips_multicycle_vn_ws #(
    parameter int             N        = 32,
    parameter logic [N-1:0]   RESET_PC = 32'h00400000,
    parameter int             MEM_TMO  = 16,
    parameter int             CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    output logic [N-1:0]      mem_addr,
    output logic [N-1:0]      mem_wr_data,
    output logic              mem_wr_ena,
    output logic              mem_req,
    input  logic              mem_rdy,
    input  logic [N-1:0]      mem_rd_data,
    output logic [N-1:0]      PC,
    output logic [32*N-1:0]   full_register_file,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);
    localparam int TMO_W = $clog2(MEM_TMO + 1);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL   = 6'h03, OP_BEQ  = 6'h04,
                           OP_BNE   = 6'h05, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI   = 6'h0D, OP_XORI = 6'h0E,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW    = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                           F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23,
                           F_AND = 6'h24, F_OR  = 6'h25, F_XOR = 6'h26, F_NOR  = 6'h27,
                           F_SLT = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_FAULT
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_pc, r_pc4, r_ir, r_a, r_b, r_alu;
    logic [N-1:0]       r_rf [0:31];
    logic [TMO_W-1:0]   r_tmo;
    logic [CNT_W-1:0]   r_retired;

    logic [5:0]         w_op, w_funct;
    logic [4:0]         w_rs, w_rt, w_rd, w_shamt, w_dest;
    logic [N-1:0]       w_imm_s, w_imm_z, w_alu, w_br_target, w_j_target;
    logic               w_valid, w_br_taken, w_is_sw, w_tmo_hit;

    assign w_op        = r_ir[31:26];
    assign w_funct     = r_ir[5:0];
    assign w_rs        = r_ir[25:21];
    assign w_rt        = r_ir[20:16];
    assign w_rd        = r_ir[15:11];
    assign w_shamt     = r_ir[10:6];
    assign w_dest      = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_imm_s     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_imm_z     = {16'b0, r_ir[15:0]};
    assign w_br_taken  = (w_op == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);
    assign w_br_target = r_pc4 + (w_imm_s << 2);
    assign w_j_target  = {r_pc4[31:28], r_ir[25:0], 2'b00};
    assign w_is_sw     = (w_op == OP_SW);
    assign w_tmo_hit   = (r_tmo == TMO_W'(MEM_TMO - 1));

    always_comb begin
        w_valid = 1'b0;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                F_SLL, F_SRL, F_SRA, F_JR, F_ADD, F_ADDU, F_SUB, F_SUBU,
                F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: w_valid = 1'b1;
                default: w_valid = 1'b0;
            endcase
        end else begin
            case (w_op)
                OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: w_valid = 1'b1;
                default: w_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_alu = '0;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                F_ADD, F_ADDU: w_alu = r_a + r_b;
                F_SUB, F_SUBU: w_alu = r_a - r_b;
                F_AND:         w_alu = r_a & r_b;
                F_OR:          w_alu = r_a | r_b;
                F_XOR:         w_alu = r_a ^ r_b;
                F_NOR:         w_alu = ~(r_a | r_b);
                F_SLT:         w_alu = {{(N-1){1'b0}}, $signed(r_a) < $signed(r_b)};
                F_SLTU:        w_alu = {{(N-1){1'b0}}, r_a < r_b};
                F_SLL:         w_alu = r_b << w_shamt;
                F_SRL:         w_alu = r_b >> w_shamt;
                F_SRA:         w_alu = $signed(r_b) >>> w_shamt;
                default:       w_alu = '0;
            endcase
        end else begin
            case (w_op)
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW: w_alu = r_a + w_imm_s;
                OP_SLTI:  w_alu = {{(N-1){1'b0}}, $signed(r_a) < $signed(w_imm_s)};
                OP_SLTIU: w_alu = {{(N-1){1'b0}}, r_a < w_imm_s};
                OP_ANDI:  w_alu = r_a & w_imm_z;
                OP_ORI:   w_alu = r_a | w_imm_z;
                OP_XORI:  w_alu = r_a ^ w_imm_z;
                OP_LUI:   w_alu = {r_ir[15:0], 16'b0};
                default:  w_alu = '0;
            endcase
        end
    end

    // Handshake: mem_req high in FETCH/MEMORY while running; addr/data/wr come only from
    // registers that hold until the cycle where mem_req & mem_rdy completes the transfer.
    assign mem_req     = (r_state == S_FETCH || r_state == S_MEMORY) && ena && !rst;
    assign mem_wr_ena  = (r_state == S_MEMORY) && w_is_sw && ena && !rst;
    assign mem_addr    = (r_state == S_MEMORY) ? r_alu : r_pc;
    assign mem_wr_data = r_b;
    assign PC          = r_pc;
    assign fault       = (r_state == S_FAULT);
    assign retired     = r_retired;

    for (genvar gi = 0; gi < 32; gi++) begin : g_rf_flat
        assign full_register_file[gi*N +: N] = r_rf[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_pc4     <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_tmo     <= '0;
            r_retired <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (ena) begin
            case (r_state)
                S_FETCH: begin
                    if (mem_rdy) begin
                        r_ir    <= mem_rd_data;
                        r_pc4   <= r_pc + 32'd4;
                        r_tmo   <= '0;
                        r_state <= S_DECODE;
                    end else if (w_tmo_hit) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (!w_valid) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_a     <= r_rf[w_rs];
                        r_b     <= r_rf[w_rt];
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (w_op == OP_RTYPE && w_funct == F_JR) begin
                        if (r_a[1:0] != 2'b00) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_pc      <= r_a;
                            r_retired <= r_retired + 1'b1;
                            r_state   <= S_FETCH;
                        end
                    end else if (w_op == OP_BEQ || w_op == OP_BNE) begin
                        r_pc      <= w_br_taken ? w_br_target : r_pc4;
                        r_retired <= r_retired + 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_op == OP_J || w_op == OP_JAL) begin
                        if (w_op == OP_JAL) r_rf[31] <= r_pc4;
                        r_pc      <= w_j_target;
                        r_retired <= r_retired + 1'b1;
                        r_state   <= S_FETCH;
                    end else if (w_op == OP_LW || w_op == OP_SW) begin
                        if (w_alu[1:0] != 2'b00) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_alu   <= w_alu;
                            r_state <= S_MEMORY;
                        end
                    end else begin
                        r_alu   <= w_alu;
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (mem_rdy) begin
                        r_tmo <= '0;
                        if (w_is_sw) begin
                            r_pc      <= r_pc4;
                            r_retired <= r_retired + 1'b1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_alu   <= mem_rd_data;
                            r_state <= S_WRITEBACK;
                        end
                    end else if (w_tmo_hit) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    if (w_dest != 5'd0) r_rf[w_dest] <= r_alu;
                    r_pc      <= r_pc4;
                    r_retired <= r_retired + 1'b1;
                    r_state   <= S_FETCH;
                end
                default: r_state <= S_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_vn_ws.sv
// Directed bench: unified memory responder with programmable wait states and hand-computed
// expectations for arithmetic, load/store, control flow, timeout, fault and ena-freeze cases.
module tb_mips_multicycle_vn_ws;
    localparam logic [31:0] RPC = 32'h00400000;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b1;
    logic [31:0]   mem_addr, mem_wr_data, mem_rd_data, PC;
    logic          mem_wr_ena, mem_req, mem_rdy, fault;
    logic [1023:0] full_register_file;
    logic [31:0]   retired;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:127];
    int          wait_states = 0;
    int          wcnt = 0;
    bit          hold_low = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] p_addr, p_data;
    logic        p_wr;
    int          st_cnt = 0;
    logic [31:0] st_addr = '0;

    mips_multicycle_vn_ws #(.N(32), .RESET_PC(RPC), .MEM_TMO(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_ena(mem_wr_ena),
        .mem_req(mem_req), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data),
        .PC(PC), .full_register_file(full_register_file), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [31:0] a);
        return int'({a[22], a[7:2]});
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input logic [25:0] t);
        return {6'(op), t};
    endfunction

    function automatic logic [31:0] rg(input int i);
        return full_register_file[i*32 +: 32];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder: ready after wait_states stalled cycles of a pending request.
    always @(negedge clk) begin
        if (mem_req && !hold_low && wcnt >= wait_states) begin
            mem_rdy     = 1'b1;
            mem_rd_data = mem[idx(mem_addr)];
        end else begin
            mem_rdy     = 1'b0;
            mem_rd_data = '0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            pend = 1'b0;
            wcnt = 0;
        end else if (mem_req) begin
            if (pend) begin
                chk("stable_addr", mem_addr, p_addr);
                chk("stable_wr", {31'd0, mem_wr_ena}, {31'd0, p_wr});
                if (p_wr) chk("stable_data", mem_wr_data, p_data);
            end
            if (mem_rdy) begin
                if (mem_wr_ena) begin
                    mem[idx(mem_addr)] = mem_wr_data;
                    st_cnt++;
                    st_addr = mem_addr;
                end
                pend = 1'b0;
                wcnt = 0;
            end else begin
                if (!pend) begin
                    p_addr = mem_addr;
                    p_data = mem_wr_data;
                    p_wr   = mem_wr_ena;
                end
                pend = 1'b1;
                wcnt++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) mem[i] = '0;
        st_cnt = 0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[idx(a)] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b1;
        hold_low = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // arithmetic with zero wait states, plus reset state
        clear_mem();
        wait_states = 0;
        put(RPC + 0, enc_i(8, 0, 1, 16'hFFFB));
        put(RPC + 4, enc_i(9, 0, 2, 16'd7));
        put(RPC + 8, enc_r(1, 2, 3, 0, 6'h20));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_wr", {31'd0, mem_wr_ena}, 32'd0);
        chk("rst_pc", PC, RPC);
        chk("rst_retired", retired, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_r31", rg(31), 32'd0);
        rst = 1'b0;
        step(12);
        chk("alu_r1", rg(1), 32'hFFFFFFFB);
        chk("alu_r2", rg(2), 32'd7);
        chk("alu_r3", rg(3), 32'd2);
        chk("alu_retired", retired, 32'd3);
        chk("alu_pc", PC, RPC + 12);

        // store then load with three wait states on every transaction
        clear_mem();
        wait_states = 3;
        put(RPC + 0, enc_i(8, 0, 3, 16'd2));
        put(RPC + 4, enc_i(6'h2B, 0, 3, 16'h0010));
        put(RPC + 8, enc_i(6'h23, 0, 4, 16'h0010));
        do_reset();
        step(17);
        chk("sw_retired", retired, 32'd2);
        chk("sw_count", 32'(st_cnt), 32'd1);
        chk("sw_addr", st_addr, 32'h10);
        chk("sw_mem", mem[idx(32'h10)], 32'd2);
        step(10);
        chk("lw_r4_early", rg(4), 32'd0);
        step(1);
        chk("lw_r4", rg(4), 32'd2);
        chk("lw_retired", retired, 32'd3);

        // branches, jumps, logical immediates, shifts
        clear_mem();
        wait_states = 0;
        put(RPC + 32'h00, enc_i(4, 0, 0, 16'd2));
        put(RPC + 32'h04, enc_i(8, 0, 7, 16'd1));
        put(RPC + 32'h08, enc_i(8, 0, 7, 16'd2));
        put(RPC + 32'h0C, enc_i(5, 0, 0, 16'd5));
        put(RPC + 32'h10, enc_j(3, 26'h0100008));
        put(RPC + 32'h14, enc_i(13, 0, 5, 16'h8000));
        put(RPC + 32'h18, enc_i(15, 0, 6, 16'h1234));
        put(RPC + 32'h1C, enc_j(2, 26'h010000C));
        put(RPC + 32'h20, enc_r(31, 0, 0, 0, 6'h08));
        put(RPC + 32'h30, enc_r(0, 5, 9, 0, 6'h23));
        put(RPC + 32'h34, enc_r(0, 9, 10, 4, 6'h03));
        put(RPC + 32'h38, enc_r(5, 9, 11, 0, 6'h2B));
        do_reset();
        step(3);
        chk("beq_pc", PC, RPC + 12);
        chk("beq_retired", retired, 32'd1);
        step(3);
        chk("bne_pc", PC, RPC + 16);
        step(3);
        chk("jal_pc", PC, RPC + 32'h20);
        chk("jal_r31", rg(31), RPC + 32'h14);
        step(3);
        chk("jr_pc", PC, RPC + 32'h14);
        step(8);
        chk("ori_r5", rg(5), 32'h00008000);
        chk("lui_r6", rg(6), 32'h12340000);
        step(3);
        chk("j_pc", PC, RPC + 32'h30);
        step(12);
        chk("subu_r9", rg(9), 32'hFFFF8000);
        chk("sra_r10", rg(10), 32'hFFFFF800);
        chk("sltu_r11", rg(11), 32'd1);
        chk("skip_r7", rg(7), 32'd0);
        chk("ctl_retired", retired, 32'd10);
        chk("ctl_pc", PC, RPC + 32'h3C);

        // fetch timeout leads to sticky fault
        clear_mem();
        wait_states = 0;
        put(RPC, enc_i(8, 0, 1, 16'd3));
        do_reset();
        step(4);
        hold_low = 1'b1;
        step(TMO - 1);
        chk("tmo_not_yet", {31'd0, fault}, 32'd0);
        step(1);
        chk("tmo_fault", {31'd0, fault}, 32'd1);
        chk("tmo_pc", PC, RPC + 4);
        step(5);
        chk("tmo_retired", retired, 32'd1);
        chk("tmo_sticky", {31'd0, fault}, 32'd1);
        chk("tmo_req", {31'd0, mem_req}, 32'd0);
        do_reset();
        chk("tmo_rst_clear", {31'd0, fault}, 32'd0);
        chk("tmo_rst_pc", PC, RPC);

        // misaligned load faults in EXECUTE without writing rt
        clear_mem();
        put(RPC, enc_i(6'h23, 0, 4, 16'h0002));
        do_reset();
        step(3);
        chk("lwmis_fault", {31'd0, fault}, 32'd1);
        chk("lwmis_pc", PC, RPC);
        chk("lwmis_retired", retired, 32'd0);
        chk("lwmis_r4", rg(4), 32'd0);

        // undefined opcode faults in DECODE
        clear_mem();
        put(RPC, 32'hFC000000);
        do_reset();
        step(2);
        chk("undef_fault", {31'd0, fault}, 32'd1);
        chk("undef_pc", PC, RPC);

        // lw with two wait states: reference timing, then with a 5-cycle ena gap
        for (int pass = 0; pass < 2; pass++) begin
            clear_mem();
            wait_states = 2;
            put(RPC + 0, enc_i(8, 0, 3, 16'h0055));
            put(RPC + 4, enc_i(6'h23, 0, 4, 16'h0010));
            put(32'h10, 32'hDEADBEEF);
            do_reset();
            if (pass == 1) begin
                step(12);
                ena = 1'b0;
                step(5);
                chk("ena_req_low", {31'd0, mem_req}, 32'd0);
                chk("ena_r4_frozen", rg(4), 32'd0);
                ena = 1'b1;
                step(2);
            end else begin
                step(14);
            end
            chk($sformatf("ena%0d_r4_before", pass), rg(4), 32'd0);
            chk($sformatf("ena%0d_ret_before", pass), retired, 32'd1);
            step(1);
            chk($sformatf("ena%0d_r4", pass), rg(4), 32'hDEADBEEF);
            chk($sformatf("ena%0d_retired", pass), retired, 32'd2);
            chk($sformatf("ena%0d_r3", pass), rg(3), 32'h55);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
